// File: rtl/cos_range_reduce.sv
// Argument reduction front-end for the cos core: folds any signed Q.14 angle into [0, pi/2],
// runs one core transaction and restores the sign. Optional watchdog: define COS_TIMEOUT_EN.
module cos_range_reduce #(
    parameter int W_ANG   = 20,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W_ANG-1:0] ang_i,
    output logic                    cos_start,
    output logic [15:0]             cos_x,
    input  logic                    cos_done,
    input  logic [17:0]             cos_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [18:0]             res_o,
    output logic                    err_o
);

    localparam int MW = W_ANG + 1;
    localparam logic [MW-1:0] PI      = MW'(51472);
    localparam logic [MW-1:0] TWO_PI  = MW'(102944);
    localparam logic [MW-1:0] HALF_PI = MW'(25736);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_FOLD,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mag_q, mag_d;
    logic            neg_q, neg_d;
    logic [15:0]     cosX_q, cosX_d;
    logic [18:0]     res_q, res_d;
    logic            outValid_q, outValid_d;
    logic            timeoutHit;

    logic [MW-1:0]   angExt, angAbs, m1, foldX;
    logic            foldNeg;

    // One extra bit so that |-2^(W_ANG-1)| is representable.
    assign angExt  = {ang_i[W_ANG-1], ang_i};
    assign angAbs  = ang_i[W_ANG-1] ? (~angExt + MW'(1)) : angExt;
    assign m1      = (mag_q > PI) ? (TWO_PI - mag_q) : mag_q;
    assign foldNeg = (m1 > HALF_PI);
    assign foldX   = foldNeg ? (PI - m1) : m1;

`ifdef COS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign timeoutHit = (state_q == S_WAIT) && !cos_done && (cnt_q == CW'(TIMEOUT - 1));
    assign cnt_d      = (state_q == S_WAIT) ? cnt_q + CW'(1) : '0;

    always_comb begin
        err_d = err_q;
        if (timeoutHit)
            err_d = 1'b1;
        else if (state_q == S_OUT && out_ready)
            err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            neg_q      <= 1'b0;
            cosX_q     <= '0;
            res_q      <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            neg_q      <= neg_d;
            cosX_q     <= cosX_d;
            res_q      <= res_d;
            outValid_q <= outValid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_SUB;
            S_SUB:   if (mag_q < TWO_PI) state_d = S_FOLD;
            S_FOLD:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (cos_done || timeoutHit) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mag_d      = mag_q;
        neg_d      = neg_q;
        cosX_d     = cosX_q;
        res_d      = res_q;
        outValid_d = outValid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_d = angAbs;
                    neg_d = 1'b0;
                end
            end
            S_SUB: begin
                if (mag_q >= TWO_PI) mag_d = mag_q - TWO_PI;
            end
            S_FOLD: begin
                cosX_d = foldX[15:0];
                neg_d  = foldNeg;
            end
            S_WAIT: begin
                if (cos_done) begin
                    res_d      = neg_q ? (~{1'b0, cos_r} + 19'd1) : {1'b0, cos_r};
                    outValid_d = 1'b1;
                end else if (timeoutHit) begin
                    res_d      = '0;
                    outValid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) outValid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        cos_start = (state_q == S_START);
    end

    assign cos_x     = cosX_q;
    assign res_o     = res_q;
    assign out_valid = outValid_q;

endmodule
